// File: rtl/galaksija_ps2_pkg.sv
// Shared types and byte constants for the Galaksija PS/2 keyboard decoder.
package galaksija_ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_REL        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/galaksija_ps2_filter.sv
// Two-flop synchronizer plus stability filter for one raw PS/2 line.
module galaksija_ps2_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic line_sync,
    output logic level,
    output logic fall_stb
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter tracks how long the synchronized line has disagreed with the accepted level.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_sync = sync2_q;
    assign level     = level_q;
    assign fall_stb  = fall_q;

endmodule

// File: rtl/galaksija_ps2_decoder.sv
// PS/2 frame receiver with E0/F0 prefix tracking and Pause-sequence swallowing.
module galaksija_ps2_decoder
    import galaksija_ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        byte_stb,
    output logic        frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic clk_sync, clk_level, clk_fall;
    logic data_sync, data_level, data_fall;
    logic unused_lines;

    galaksija_ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_in  (ps2_clk),
        .line_sync(clk_sync),
        .level    (clk_level),
        .fall_stb (clk_fall)
    );

    galaksija_ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_in  (ps2_data),
        .line_sync(data_sync),
        .level    (data_level),
        .fall_stb (data_fall)
    );

    assign unused_lines = ^{clk_sync, clk_level, data_level, data_fall};

    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ext_q, ext_d;
    logic             rel_q, rel_d;
    logic [2:0]       skip_q, skip_d;
    logic [10:0]      ps2_key_q, ps2_key_d;
    logic             byte_stb_q, byte_stb_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = '0;
        ext_d       = ext_q;
        rel_d       = rel_q;
        skip_d      = skip_q;
        ps2_key_d   = ps2_key_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clk_fall && !data_sync) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (clk_fall) begin
                    shift_d   = {data_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    parity_d = data_sync;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    state_d = ST_IDLE;
                    // Odd parity over data+parity, and a high stop bit, make the frame good.
                    if ((^{shift_q, parity_q}) && data_sync) begin
                        byte_stb_d = 1'b1;
                        if (skip_q != 3'd0) begin
                            skip_d = skip_q - 3'd1;
                        end else begin
                            case (shift_q)
                                PS2_PAUSE: skip_d = PS2_PAUSE_SKIP;
                                PS2_EXT:   ext_d  = 1'b1;
                                PS2_REL:   rel_d  = 1'b1;
                                default: begin
                                    ps2_key_d = {~ps2_key_q[10], ~rel_q, ext_q, shift_q};
                                    ext_d     = 1'b0;
                                    rel_d     = 1'b0;
                                end
                            endcase
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        rel_d       = 1'b0;
                        skip_d      = 3'd0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled keyboard mid-frame aborts the frame but leaves prefix state intact.
        if (state_q != ST_IDLE && !clk_fall) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= 3'd0;
            ps2_key_q   <= 11'd0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            skip_q      <= skip_d;
            ps2_key_q   <= ps2_key_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ps2_key   = ps2_key_q;
    assign byte_stb  = byte_stb_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/galaksija_ps2_decoder.md
GALAKSIJA_PS2_DECODER -- requirements
Module: galaksija_ps2_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 4, giving the cycles a synchronized ps2_clk level must be stable before it is accepted.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 50000, giving the idle cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 Port clk  in  1  system clock; all logic on its rising edge.
REQ-004 Port reset_n  in  1  reset; asynchronous, active-low.
REQ-005 Port ps2_clk  in  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 Port ps2_data  in  1  raw PS/2 data line, asynchronous to clk.
REQ-007 Port ps2_key  out  11  key event: [10] toggle-per-event, [9] pressed, [8] extended, [7:0] scan code.
REQ-008 Port byte_stb  out  1  one-cycle pulse per correctly received byte, including prefixes.
REQ-009 Port frame_err  out  1  one-cycle pulse on parity error, stop-bit error or timeout.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-011 The filtered clock SHALL change state only after the synchronized clock holds the new level for FILTER_LEN consecutive cycles.
REQ-012 The synchronized data SHALL be sampled on the cycle in which the filtered clock falls.
REQ-013 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: a sampled 0 SHALL go to DATA with the bit count cleared; a sampled 1 SHALL stay in IDLE with no error.
REQ-015 DATA: the FSM SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-016 PARITY: the FSM SHALL store the sampled bit and go to STOP.
REQ-017 STOP: the frame is valid if the XOR of the 8 data bits and the parity bit is 1 and the sampled stop bit is 1.
REQ-018 After STOP the FSM SHALL return to IDLE whether or not the frame is valid.
REQ-019 On an invalid frame the block SHALL pulse frame_err, discard the byte, and clear the ext, rel and skip state.
REQ-020 In any state other than IDLE, TIMEOUT_CYC cycles with no filtered falling edge SHALL force IDLE and pulse frame_err; the partial byte is discarded and the prefix flags are kept.
REQ-021 On each valid frame, byte_stb SHALL pulse 1 cycle after the stop-bit sample.
REQ-022 Byte handling SHALL occur in the same cycle as byte_stb.
REQ-023 If skip_cnt != 0, the byte SHALL be consumed and skip_cnt decremented; no other action.
REQ-024 Byte 0xE1 SHALL load skip_cnt = 7, swallowing the Pause sequence; no event.
REQ-025 Byte 0xE0 SHALL set ext; no event.
REQ-026 Byte 0xF0 SHALL set rel; no event.
REQ-027 Any other byte SHALL write ps2_key = {~ps2_key[10], ~rel, ext, byte} and then clear ext and rel.
REQ-028 Event latency SHALL be 1 clk from the stop-bit sample to the ps2_key update.
REQ-029 ps2_key SHALL hold its value between events.
REQ-030 Consecutive identical make codes (typematic repeat) SHALL each produce a new event, with bit 10 toggled.
REQ-031 byte_stb and frame_err SHALL never assert in the same cycle.

Reset
REQ-032 While reset_n = 0, all of the following SHALL be 0: ps2_key, byte_stb, frame_err, ext, rel, skip_cnt, bit count, shift register, filter counter, timeout counter.
REQ-033 While reset_n = 0, the FSM SHALL be in IDLE and the synchronizers and filtered clock SHALL hold 1 (bus idle level).
REQ-034 Reset asserted mid-frame SHALL drop the partial frame with no event and no error pulse.
REQ-035 After reset release, decoding SHALL resume at the next start bit.

Structure
REQ-036 Package galaksija_ps2_pkg SHALL hold the FSM state enum, the constants PS2_EXT = 8'hE0, PS2_REL = 8'hF0 and PS2_PAUSE = 8'hE1, and the pause skip count 7.
REQ-037 The synchronizer and glitch filter SHALL be a sub-module named galaksija_ps2_filter, instantiated once per line.
REQ-038 galaksija_ps2_filter SHALL output the filtered level and a falling-edge strobe.
REQ-039 The frame FSM and prefix logic SHALL reside in galaksija_ps2_decoder.

Verification
REQ-040 Send 0x1C with good parity -> 1 byte_stb; ps2_key = {1,1,0,0x1C}.
REQ-041 Send F0,1C after REQ-040 -> 2 byte_stb; ps2_key = {0,0,0,0x1C}.
REQ-042 Send E0,75 then E0,F0,75 -> ps2_key = {1,1,1,0x75}, then {0,0,1,0x75}.
REQ-043 Send 0x1C with parity flipped, then 0x32 -> 1 frame_err and no event for the first byte; ps2_key[7:0] = 0x32 with ext = 0 and rel = 0.
REQ-044 Send start bit plus 3 data bits, then idle TIMEOUT_CYC+2 cycles, then a full 0x29 frame -> 1 frame_err; ps2_key[7:0] = 0x29.
REQ-045 Send E1,14,77,E1,F0,14,F0,77 then 0x1C -> no event from the Pause bytes; 1 event, 0x1C pressed.
REQ-046 Inject 2-cycle low glitches on ps2_clk while idle and assert reset_n = 0 mid-frame -> no byte_stb, no frame_err, ps2_key = 0.
